// File: rtl/dmem_controller.sv
// Data-memory controller: round-robin arbitration of cache request ports onto
// independent memory channels, each channel running a 4-phase valid/ready handshake.
module dmem_controller #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1,
    parameter bit WRITE_ENABLE  = 1'b1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]            mem_read_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
    output logic [NUM_CHANNELS-1:0]            mem_write_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
    output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
    input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);
    localparam int NC  = NUM_CONSUMERS;
    localparam int NCH = NUM_CHANNELS;
    localparam int IDW = (NC > 1) ? $clog2(NC) : 1;

    typedef enum logic [2:0] {
        IDLE           = 3'd0,
        READ_WAITING   = 3'd1,
        WRITE_WAITING  = 3'd2,
        READ_RELAYING  = 3'd3,
        WRITE_RELAYING = 3'd4
    } state_t;

    state_t [NCH-1:0]                state_q;
    logic   [NCH-1:0][IDW-1:0]       id_q;
    logic   [NCH-1:0][IDW-1:0]       rr_ptr_q;
    logic   [NC-1:0]                 serving_q;
    logic   [NCH-1:0]                mem_rvalid_q;
    logic   [NCH-1:0]                mem_wvalid_q;
    logic   [NCH-1:0][ADDR_BITS-1:0] mem_raddr_q;
    logic   [NCH-1:0][ADDR_BITS-1:0] mem_waddr_q;
    logic   [NCH-1:0][DATA_BITS-1:0] mem_wdata_q;
    logic   [NC-1:0]                 cons_rready_q;
    logic   [NC-1:0]                 cons_wready_q;
    logic   [NC-1:0][DATA_BITS-1:0]  cons_rdata_q;

    logic   [NC-1:0][ADDR_BITS-1:0]  c_raddr_s;
    logic   [NC-1:0][ADDR_BITS-1:0]  c_waddr_s;
    logic   [NC-1:0][DATA_BITS-1:0]  c_wdata_s;
    logic   [NCH-1:0][DATA_BITS-1:0] m_rdata_s;
    logic   [NC-1:0]                 c_wvalid_s;

    logic   [NCH-1:0]                grant_s;
    logic   [NCH-1:0]                grant_rd_s;
    logic   [NCH-1:0][IDW-1:0]       grant_id_s;
    logic   [NC-1:0]                 taken_s;
    logic   [IDW-1:0]                scan_sel_s;
    logic                            found_s;

    assign c_raddr_s  = consumer_read_address;
    assign c_waddr_s  = consumer_write_address;
    assign c_wdata_s  = consumer_write_data;
    assign m_rdata_s  = mem_read_data;
    assign c_wvalid_s = WRITE_ENABLE ? consumer_write_valid : {NC{1'b0}};

    // Grant selection; a consumer claimed by a lower channel is busy for higher channels.
    always_comb begin
        taken_s    = serving_q;
        grant_s    = {NCH{1'b0}};
        grant_rd_s = {NCH{1'b0}};
        grant_id_s = {(NCH*IDW){1'b0}};
        scan_sel_s = {IDW{1'b0}};
        found_s    = 1'b0;
        for (int ch = 0; ch < NCH; ch++) begin
            found_s = 1'b0;
            if (state_q[ch] == IDLE) begin
                for (int k = 0; k < NC; k++) begin
                    scan_sel_s = IDW'((int'(rr_ptr_q[ch]) + k) % NC);
                    if (!found_s && !taken_s[scan_sel_s] &&
                        (consumer_read_valid[scan_sel_s] || c_wvalid_s[scan_sel_s])) begin
                        found_s        = 1'b1;
                        grant_id_s[ch] = scan_sel_s;
                        grant_rd_s[ch] = consumer_read_valid[scan_sel_s];
                    end else begin
                        found_s = found_s;
                    end
                end
                if (found_s) begin
                    grant_s[ch]             = 1'b1;
                    taken_s[grant_id_s[ch]] = 1'b1;
                end else begin
                    grant_s[ch] = 1'b0;
                end
            end else begin
                grant_s[ch] = 1'b0;
            end
        end
    end

    // Per-channel handshake FSMs and every registered output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            serving_q     <= {NC{1'b0}};
            cons_rready_q <= {NC{1'b0}};
            cons_wready_q <= {NC{1'b0}};
            cons_rdata_q  <= {(NC*DATA_BITS){1'b0}};
            mem_rvalid_q  <= {NCH{1'b0}};
            mem_wvalid_q  <= {NCH{1'b0}};
            mem_raddr_q   <= {(NCH*ADDR_BITS){1'b0}};
            mem_waddr_q   <= {(NCH*ADDR_BITS){1'b0}};
            mem_wdata_q   <= {(NCH*DATA_BITS){1'b0}};
            id_q          <= {(NCH*IDW){1'b0}};
            rr_ptr_q      <= {(NCH*IDW){1'b0}};
            for (int ch = 0; ch < NCH; ch++) begin
                state_q[ch] <= IDLE;
            end
        end else begin
            for (int ch = 0; ch < NCH; ch++) begin
                case (state_q[ch])
                    IDLE: begin
                        if (grant_s[ch]) begin
                            id_q[ch]                 <= grant_id_s[ch];
                            serving_q[grant_id_s[ch]] <= 1'b1;
                            if (grant_rd_s[ch]) begin
                                mem_rvalid_q[ch] <= 1'b1;
                                mem_raddr_q[ch]  <= c_raddr_s[grant_id_s[ch]];
                                state_q[ch]      <= READ_WAITING;
                            end else begin
                                mem_wvalid_q[ch] <= 1'b1;
                                mem_waddr_q[ch]  <= c_waddr_s[grant_id_s[ch]];
                                mem_wdata_q[ch]  <= c_wdata_s[grant_id_s[ch]];
                                state_q[ch]      <= WRITE_WAITING;
                            end
                        end
                    end
                    READ_WAITING: begin
                        if (mem_read_ready[ch]) begin
                            mem_rvalid_q[ch]        <= 1'b0;
                            cons_rdata_q[id_q[ch]]  <= m_rdata_s[ch];
                            cons_rready_q[id_q[ch]] <= 1'b1;
                            state_q[ch]             <= READ_RELAYING;
                        end
                    end
                    WRITE_WAITING: begin
                        if (mem_write_ready[ch]) begin
                            mem_wvalid_q[ch]        <= 1'b0;
                            cons_wready_q[id_q[ch]] <= 1'b1;
                            state_q[ch]             <= WRITE_RELAYING;
                        end
                    end
                    READ_RELAYING: begin
                        if (!consumer_read_valid[id_q[ch]]) begin
                            cons_rready_q[id_q[ch]] <= 1'b0;
                            cons_rdata_q[id_q[ch]]  <= {DATA_BITS{1'b0}};
                            serving_q[id_q[ch]]     <= 1'b0;
                            rr_ptr_q[ch]            <= (id_q[ch] == IDW'(NC - 1)) ?
                                                       {IDW{1'b0}} : id_q[ch] + IDW'(1);
                            state_q[ch]             <= IDLE;
                        end
                    end
                    WRITE_RELAYING: begin
                        if (!c_wvalid_s[id_q[ch]]) begin
                            cons_wready_q[id_q[ch]] <= 1'b0;
                            cons_rdata_q[id_q[ch]]  <= {DATA_BITS{1'b0}};
                            serving_q[id_q[ch]]     <= 1'b0;
                            rr_ptr_q[ch]            <= (id_q[ch] == IDW'(NC - 1)) ?
                                                       {IDW{1'b0}} : id_q[ch] + IDW'(1);
                            state_q[ch]             <= IDLE;
                        end
                    end
                    default: state_q[ch] <= IDLE;
                endcase
            end
        end
    end

    assign consumer_read_ready  = cons_rready_q;
    assign consumer_read_data   = cons_rdata_q;
    assign mem_read_valid       = mem_rvalid_q;
    assign mem_read_address     = mem_raddr_q;
    assign consumer_write_ready = WRITE_ENABLE ? cons_wready_q : {NC{1'b0}};
    assign mem_write_valid      = WRITE_ENABLE ? mem_wvalid_q : {NCH{1'b0}};
    assign mem_write_address    = WRITE_ENABLE ? mem_waddr_q : {(NCH*ADDR_BITS){1'b0}};
    assign mem_write_data       = WRITE_ENABLE ? mem_wdata_q : {(NCH*DATA_BITS){1'b0}};

endmodule

// File: tb/tb_dmem_controller.sv
// Self-checking bench: a single-channel and a dual-channel controller driven against a
// round-robin request model and a bench-side memory responder.
`timescale 1ns/1ps
module tb_dmem_controller;
    localparam int NC = 4;
    localparam int AB = 8;
    localparam int DB = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [NC-1:0]    a_rv, a_rr, a_wv, a_wr;
    logic [NC*AB-1:0] a_raddr, a_waddr;
    logic [NC*DB-1:0] a_rdata, a_wdata;
    logic             a_mrv, a_mrr, a_mwv, a_mwr;
    logic [AB-1:0]    a_mra, a_mwa;
    logic [DB-1:0]    a_mrd, a_mwd;

    logic [NC-1:0]    b_rv, b_rr, b_wv, b_wr;
    logic [NC*AB-1:0] b_raddr, b_waddr;
    logic [NC*DB-1:0] b_rdata, b_wdata;
    logic [1:0]       b_mrv, b_mrr, b_mwv, b_mwr;
    logic [2*AB-1:0]  b_mra, b_mwa;
    logic [2*DB-1:0]  b_mrd, b_mwd;

    dmem_controller #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC),
                      .NUM_CHANNELS(1), .WRITE_ENABLE(1'b1)) dut_a (
        .clk(clk), .reset(reset),
        .consumer_read_valid(a_rv), .consumer_read_address(a_raddr),
        .consumer_read_ready(a_rr), .consumer_read_data(a_rdata),
        .consumer_write_valid(a_wv), .consumer_write_address(a_waddr),
        .consumer_write_data(a_wdata), .consumer_write_ready(a_wr),
        .mem_read_valid(a_mrv), .mem_read_address(a_mra),
        .mem_read_ready(a_mrr), .mem_read_data(a_mrd),
        .mem_write_valid(a_mwv), .mem_write_address(a_mwa),
        .mem_write_data(a_mwd), .mem_write_ready(a_mwr));

    dmem_controller #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC),
                      .NUM_CHANNELS(2), .WRITE_ENABLE(1'b1)) dut_b (
        .clk(clk), .reset(reset),
        .consumer_read_valid(b_rv), .consumer_read_address(b_raddr),
        .consumer_read_ready(b_rr), .consumer_read_data(b_rdata),
        .consumer_write_valid(b_wv), .consumer_write_address(b_waddr),
        .consumer_write_data(b_wdata), .consumer_write_ready(b_wr),
        .mem_read_valid(b_mrv), .mem_read_address(b_mra),
        .mem_read_ready(b_mrr), .mem_read_data(b_mrd),
        .mem_write_valid(b_mwv), .mem_write_address(b_mwa),
        .mem_write_data(b_mwd), .mem_write_ready(b_mwr));

    // Reference model state: outstanding consumer requests and round-robin pointers.
    bit       pend_rd [NC];
    bit       pend_wr [NC];
    logic [7:0] p_raddr [NC];
    logic [7:0] p_waddr [NC];
    logic [7:0] p_wdata [NC];
    int ptr   = 0;
    int bptr0 = 0;
    int bptr1 = 0;

    function automatic int pick(input int start, input bit [NC-1:0] req);
        int j;
        pick = -1;
        for (int k = 0; k < NC; k++) begin
            j = (start + k) % NC;
            if (pick < 0 && req[j]) pick = j;
        end
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NC; i++) begin
            pend_rd[i] = 1'b0; pend_wr[i] = 1'b0;
            p_raddr[i] = 8'h00; p_waddr[i] = 8'h00; p_wdata[i] = 8'h00;
        end
    endtask

    task automatic drive_a();
        for (int i = 0; i < NC; i++) begin
            a_rv[i] = pend_rd[i];
            a_wv[i] = pend_wr[i];
            a_raddr[i*AB+:AB] = p_raddr[i];
            a_waddr[i*AB+:AB] = p_waddr[i];
            a_wdata[i*DB+:DB] = p_wdata[i];
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        clear_model();
        drive_a();
        b_rv = 4'b0000;
        @(negedge clk);
        reset = 1'b0;
        ptr = 0; bptr0 = 0; bptr1 = 0;
        @(negedge clk);
    endtask

    // One complete transaction on the single-channel DUT for the consumer the model selects.
    task automatic a_serve(input int lat, input int hold, input logic [7:0] d, output int id);
        bit [NC-1:0]      req;
        bit               rd;
        logic [7:0]       ea, ed, oa;
        logic [NC-1:0]    e_rr, e_wr;
        logic [NC*DB-1:0] e_rdata;
        for (int i = 0; i < NC; i++) req[i] = pend_rd[i] | pend_wr[i];
        id = pick(ptr, req);
        if (id < 0) return;
        rd = pend_rd[id];
        ea = rd ? p_raddr[id] : p_waddr[id];
        ed = p_wdata[id];
        drive_a();
        @(negedge clk);
        for (int c = 0; c <= lat; c++) begin
            if (c == 1) begin
                a_raddr[id*AB+:AB] = ~p_raddr[id];
                a_waddr[id*AB+:AB] = ~p_waddr[id];
                a_wdata[id*DB+:DB] = ~p_wdata[id];
            end
            if (c > 0) @(negedge clk);
            oa = rd ? a_mra : a_mwa;
            checks++;
            if (a_mrv !== rd || a_mwv !== !rd || oa !== ea || (!rd && a_mwd !== ed)) begin
                errors++;
                $display("FAIL mem_request cyc%0d: mrv=%b mwv=%b addr=%h wdata=%h, required c%0d rd=%b addr=%h wdata=%h",
                         c, a_mrv, a_mwv, oa, a_mwd, id, rd, ea, ed);
            end
        end
        if (rd) begin a_mrr = 1'b1; a_mrd = d; end
        else    begin a_mwr = 1'b1; end
        @(negedge clk);
        a_mrr = 1'b0; a_mwr = 1'b0; a_mrd = 8'($urandom);
        e_rr = '0; e_wr = '0; e_rdata = '0;
        if (rd) begin e_rr[id] = 1'b1; e_rdata[id*DB+:DB] = d; end
        else    begin e_wr[id] = 1'b1; end
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) @(negedge clk);
            checks++;
            if (a_rr !== e_rr || a_wr !== e_wr || a_rdata !== e_rdata || a_mrv !== 1'b0 || a_mwv !== 1'b0) begin
                errors++;
                $display("FAIL consumer_ack: rr=%b wr=%b rdata=%h mrv=%b mwv=%b, required rr=%b wr=%b rdata=%h mem valids 0",
                         a_rr, a_wr, a_rdata, a_mrv, a_mwv, e_rr, e_wr, e_rdata);
            end
        end
        if (rd) pend_rd[id] = 1'b0;
        else    pend_wr[id] = 1'b0;
        drive_a();
        @(negedge clk);
        checks++;
        if (a_rr !== 4'b0000 || a_wr !== 4'b0000 || a_rdata !== 32'h0 || a_mrv !== 1'b0 || a_mwv !== 1'b0) begin
            errors++;
            $display("FAIL release: rr=%b wr=%b rdata=%h mrv=%b mwv=%b, required all 0",
                     a_rr, a_wr, a_rdata, a_mrv, a_mwv);
        end
        ptr = (id + 1) % NC;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_mrr = 1'b0; a_mwr = 1'b0; a_mrd = 8'h00;
        b_rv = 4'b0000; b_wv = 4'b0000; b_raddr = '0; b_waddr = '0; b_wdata = '0;
        b_mrr = 2'b00; b_mwr = 2'b00; b_mrd = 16'h0000;
        clear_model();
        drive_a();
        repeat (3) @(negedge clk);
        checks++;
        if ({a_rr, a_rdata, a_wr, a_mrv, a_mra, a_mwv, a_mwa, a_mwd} !== '0 ||
            {b_rr, b_rdata, b_wr, b_mrv, b_mra, b_mwv, b_mwa, b_mwd} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: a_mrv=%b a_rr=%b b_mrv=%b b_rr=%b, required all outputs 0",
                     a_mrv, a_rr, b_mrv, b_rr);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Two consumers request together on the dual-channel DUT; each channel takes one.
    task automatic b_round(input int c_a, input int c_b);
        bit [NC-1:0]      req;
        int               g0, g1;
        logic [7:0]       d0, d1, ea0, ea1;
        logic [NC-1:0]    e_rr;
        logic [NC*DB-1:0] e_rd;
        req = '0; req[c_a] = 1'b1; req[c_b] = 1'b1;
        g0 = pick(bptr0, req);
        req[g0] = 1'b0;
        g1 = pick(bptr1, req);
        req[g0] = 1'b1;
        ea0 = 8'h50 + 8'(g0);
        ea1 = 8'h50 + 8'(g1);
        for (int i = 0; i < NC; i++) b_raddr[i*AB+:AB] = 8'h50 + 8'(i);
        b_rv = req;
        @(negedge clk);
        checks++;
        if (b_mrv !== 2'b11 || b_mra !== {ea1, ea0}) begin
            errors++;
            $display("FAIL dual_grant: mrv=%b mra=%h, required mrv=11 mra=%h%h", b_mrv, b_mra, ea1, ea0);
        end
        d1 = 8'($urandom);
        b_mrr = 2'b10; b_mrd = {d1, 8'($urandom)};
        @(negedge clk);
        b_mrr = 2'b00;
        e_rr = '0; e_rd = '0;
        e_rr[g1] = 1'b1; e_rd[g1*DB+:DB] = d1;
        checks++;
        if (b_rr !== e_rr || b_rdata !== e_rd || b_mrv !== 2'b01) begin
            errors++;
            $display("FAIL dual_ch1_ack: rr=%b rdata=%h mrv=%b, required rr=%b rdata=%h mrv=01",
                     b_rr, b_rdata, b_mrv, e_rr, e_rd);
        end
        d0 = 8'($urandom);
        b_mrr = 2'b01; b_mrd = {8'($urandom), d0};
        @(negedge clk);
        b_mrr = 2'b00;
        e_rr[g0] = 1'b1; e_rd[g0*DB+:DB] = d0;
        checks++;
        if (b_rr !== e_rr || b_rdata !== e_rd || b_mrv !== 2'b00) begin
            errors++;
            $display("FAIL dual_ch0_ack: rr=%b rdata=%h mrv=%b, required rr=%b rdata=%h mrv=00",
                     b_rr, b_rdata, b_mrv, e_rr, e_rd);
        end
        b_rv = 4'b0000;
        @(negedge clk);
        checks++;
        if (b_rr !== 4'b0000 || b_rdata !== 32'h0 || b_mrv !== 2'b00) begin
            errors++;
            $display("FAIL dual_release: rr=%b rdata=%h mrv=%b, required all 0", b_rr, b_rdata, b_mrv);
        end
        bptr0 = (g0 + 1) % NC;
        bptr1 = (g1 + 1) % NC;
    endtask

    task automatic test_dual_channel();
        int ca;
        b_round(1, 2);
        b_round(1, 3);
        for (int r = 0; r < 4; r++) begin
            ca = int'($urandom_range(0, NC - 1));
            b_round(ca, (ca + int'($urandom_range(1, NC - 1))) % NC);
        end
    endtask

    task automatic test_single_read();
        int id;
        pend_rd[0] = 1'b1; p_raddr[0] = 8'h12;
        a_serve(3, 1, 8'hA5, id);
    endtask

    task automatic test_round_robin();
        int id;
        pulse_reset();
        for (int i = 0; i < NC; i++) begin
            pend_rd[i] = 1'b1; p_raddr[i] = 8'h20 + 8'(i);
        end
        for (int n = 0; n < 5; n++) begin
            a_serve(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 8'($urandom), id);
            if (id >= 0) pend_rd[id] = 1'b1;
        end
        clear_model();
        drive_a();
        @(negedge clk);
    endtask

    task automatic test_write();
        int id;
        pend_wr[3] = 1'b1; p_waddr[3] = 8'h40; p_wdata[3] = 8'h7F;
        a_serve(5, 0, 8'h00, id);
    endtask

    task automatic test_read_write_same();
        int id;
        pend_rd[0] = 1'b1; p_raddr[0] = 8'h0C;
        pend_wr[0] = 1'b1; p_waddr[0] = 8'h0D; p_wdata[0] = 8'h3C;
        a_serve(1, 0, 8'h96, id);
        a_serve(2, 1, 8'h00, id);
    endtask

    task automatic test_random();
        int id, kind, any;
        for (int n = 0; n < 40; n++) begin
            any = 0;
            for (int i = 0; i < NC; i++) begin
                if (!pend_rd[i] && !pend_wr[i] && $urandom_range(0, 2) == 0) begin
                    kind = int'($urandom_range(0, 2));
                    pend_rd[i] = (kind != 1);
                    pend_wr[i] = (kind != 0);
                    p_raddr[i] = 8'($urandom);
                    p_waddr[i] = 8'($urandom);
                    p_wdata[i] = 8'($urandom);
                end
                if (pend_rd[i] || pend_wr[i]) any = 1;
            end
            if (any == 0) begin
                kind = int'($urandom_range(0, NC - 1));
                pend_rd[kind] = 1'b1;
                p_raddr[kind] = 8'($urandom);
            end
            a_serve(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 8'($urandom), id);
        end
        for (int n = 0; n < 2 * NC; n++) begin
            a_serve(int'($urandom_range(0, 2)), 0, 8'($urandom), id);
        end
    endtask

    task automatic test_reset_mid_read();
        int id;
        pend_rd[2] = 1'b1; p_raddr[2] = 8'h33;
        drive_a();
        @(negedge clk);
        checks++;
        if (a_mrv !== 1'b1 || a_mra !== 8'h33) begin
            errors++;
            $display("FAIL pre_reset_grant: mrv=%b mra=%h, required mrv=1 mra=33", a_mrv, a_mra);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({a_rr, a_rdata, a_wr, a_mrv, a_mra, a_mwv, a_mwa, a_mwd} !== '0) begin
            errors++;
            $display("FAIL async_reset: mrv=%b mra=%h rr=%b, required all outputs 0", a_mrv, a_mra, a_rr);
        end
        clear_model();
        drive_a();
        @(negedge clk);
        reset = 1'b0;
        ptr = 0; bptr0 = 0; bptr1 = 0;
        a_mrr = 1'b1; a_mrd = 8'hEE;
        @(negedge clk);
        a_mrr = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (a_rr !== 4'b0000 || a_rdata !== 32'h0 || a_mrv !== 1'b0 || a_wr !== 4'b0000) begin
                errors++;
                $display("FAIL stale_ack cyc%0d: rr=%b rdata=%h mrv=%b wr=%b, required all 0",
                         c, a_rr, a_rdata, a_mrv, a_wr);
            end
            @(negedge clk);
        end
        pend_rd[2] = 1'b1; p_raddr[2] = 8'h34;
        a_serve(1, 0, 8'h5A, id);
    endtask

    initial begin
        test_reset();
        test_dual_channel();
        test_single_read();
        test_round_robin();
        test_write();
        test_read_write_same();
        test_random();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
